// File: rtl/axis_downsizer_pkg.sv
// Shared helpers for the AXI-Stream downsizer: width ratio, index sizing and
// the holding-register occupancy state.
package axis_downsizer_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_e;

    function automatic int ds_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int ds_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/axis_downsizer.sv
// AXI-Stream width downsizer: holds one wide beat and emits it as RATIO
// narrow sub-words, LSB first, trimming trailing empty sub-words on last beats.
module axis_downsizer
    import axis_downsizer_pkg::*;
#(
    parameter int in_width         = 32,
    parameter int out_width        = 16,
    parameter int user_width       = 1,
    parameter int simulation_delay = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [in_width-1:0]     s_axis_data,
    input  logic [in_width/8-1:0]   s_axis_keep,
    input  logic [user_width-1:0]   s_axis_user,
    input  logic                    s_axis_last,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,

    output logic [out_width-1:0]    m_axis_data,
    output logic [out_width/8-1:0]  m_axis_keep,
    output logic [user_width-1:0]   m_axis_user,
    output logic                    m_axis_last,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready
);

    localparam int RATIO = ds_ratio(in_width, out_width);
    localparam int IDX_W = ds_clog2(RATIO);
    localparam int OKW   = out_width / 8;

    if ((in_width % 8) != 0 || (out_width % 8) != 0 || RATIO < 2 ||
        (RATIO & (RATIO - 1)) != 0 || in_width != RATIO * out_width ||
        user_width < 1 || simulation_delay < 0) begin : g_param_check
        $error("axis_downsizer: illegal parameter combination");
    end

    hold_state_e                   state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [IDX_W-1:0]              final_idx;
    logic [RATIO-1:0][out_width-1:0] data_q;
    logic [RATIO-1:0][OKW-1:0]     keep_q;
    logic [user_width-1:0]         user_q;
    logic                          last_q;

    logic full;
    logic is_final;
    logic in_hs;
    logic out_hs;

    // Last beats stop at the highest sub-word carrying any keep bit (or 0).
    always_comb begin
        final_idx = IDX_W'(RATIO - 1);
        if (last_q) begin
            final_idx = '0;
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (|keep_q[IDX_W'(i)]) final_idx = IDX_W'(i);
            end
        end
    end

    assign full         = (state_q == ST_FULL);
    assign is_final     = (idx_q == final_idx);
    assign out_hs       = full & m_axis_ready;
    assign s_axis_ready = ~full | (out_hs & is_final);
    assign in_hs        = s_axis_valid & s_axis_ready;

    assign m_axis_valid = full;
    assign m_axis_data  = data_q[idx_q];
    assign m_axis_keep  = keep_q[idx_q];
    assign m_axis_user  = user_q;
    assign m_axis_last  = last_q & is_final;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (in_hs) begin
            state_d = ST_FULL;
            idx_d   = '0;
        end else if (out_hs) begin
            if (is_final) state_d = ST_EMPTY;
            else          idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            data_q <= s_axis_data;
            keep_q <= s_axis_keep;
            user_q <= s_axis_user;
            last_q <= s_axis_last;
        end
    end

endmodule

// File: tb/tb_axis_downsizer.sv
// Randomised and directed bench for axis_downsizer at 32->16 and 64->16,
// checked against a beat-to-sub-word expansion model.
module tb_axis_downsizer;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [1:0]  user;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic [1:0]  user;
        logic        last;
        logic        fin;
    } sub_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    beat_t       cur  [2];
    logic        svld [2];
    logic        srdy [2];
    logic        mrdy [2];
    logic        mval [2];
    logic        mlast[2];
    logic [15:0] mdat [2];
    logic [1:0]  mkeep[2];
    logic        m0_user;
    logic [1:0]  m1_user;

    axis_downsizer #(.in_width(32), .out_width(16), .user_width(1), .simulation_delay(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_data(cur[0].data[31:0]), .s_axis_keep(cur[0].keep[3:0]),
        .s_axis_user(cur[0].user[0]), .s_axis_last(cur[0].last),
        .s_axis_valid(svld[0]), .s_axis_ready(srdy[0]),
        .m_axis_data(mdat[0]), .m_axis_keep(mkeep[0]), .m_axis_user(m0_user),
        .m_axis_last(mlast[0]), .m_axis_valid(mval[0]), .m_axis_ready(mrdy[0])
    );

    axis_downsizer #(.in_width(64), .out_width(16), .user_width(2), .simulation_delay(1)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_data(cur[1].data), .s_axis_keep(cur[1].keep),
        .s_axis_user(cur[1].user), .s_axis_last(cur[1].last),
        .s_axis_valid(svld[1]), .s_axis_ready(srdy[1]),
        .m_axis_data(mdat[1]), .m_axis_keep(mkeep[1]), .m_axis_user(m1_user),
        .m_axis_last(mlast[1]), .m_axis_valid(mval[1]), .m_axis_ready(mrdy[1])
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   vprob, rprob;
    beat_t src_q[2][$];
    sub_t  exp_q[2][$];
    bit    rdy_script[$];
    logic  acc[2];
    logic  stall_prev[2];
    logic [15:0] pdat[2];
    logic [1:0]  pkeep[2];
    logic [1:0]  pusr[2];
    logic        plast[2];
    int hs_cnt[2], hs_first[2], hs_last[2], sr_cnt[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [1:0] musr(input int d);
        return (d == 0) ? {1'b0, m0_user} : m1_user;
    endfunction

    function automatic beat_t mk(input logic [63:0] data, input logic [7:0] keep,
                                 input logic [1:0] user, input logic last);
        beat_t b;
        b.data = data; b.keep = keep; b.user = user; b.last = last;
        return b;
    endfunction

    function automatic beat_t rand_beat(input int d);
        beat_t b;
        b.data = {$urandom, $urandom};
        b.keep = 8'($urandom);
        b.user = 2'($urandom);
        b.last = 1'($urandom);
        if (d == 0) begin
            b.data[63:32] = '0;
            b.keep[7:4]   = '0;
            b.user[1]     = 1'b0;
        end
        return b;
    endfunction

    // A beat becomes RATIO 16-bit pieces, or fewer on a last beat: up to the
    // piece containing the highest kept byte (at least one piece).
    function automatic void expand(input int d, input beat_t b);
        int   r;
        int   n;
        sub_t s;
        r = (d == 0) ? 2 : 4;
        n = r;
        if (b.last) begin
            n = 1;
            for (int k = 0; k < 8; k++) if (b.keep[k]) n = k / 2 + 1;
        end
        for (int i = 0; i < n; i++) begin
            s.data = 16'(b.data >> (16 * i));
            s.keep = 2'(b.keep >> (2 * i));
            s.user = b.user;
            s.fin  = (i == n - 1);
            s.last = b.last && s.fin;
            exp_q[d].push_back(s);
        end
    endfunction

    function automatic void drive();
        for (int d = 0; d < 2; d++) begin
            if (!svld[d] || acc[d]) begin
                if (src_q[d].size() > 0 && $urandom_range(99) < vprob) begin
                    cur[d]  = src_q[d].pop_front();
                    svld[d] = 1'b1;
                end else begin
                    svld[d] = 1'b0;
                end
            end
            acc[d] = 1'b0;
            if (d == 0 && rdy_script.size() > 0) mrdy[0] = rdy_script.pop_front();
            else mrdy[d] = ($urandom_range(99) < rprob);
        end
    endfunction

    function automatic void reset_stats();
        for (int d = 0; d < 2; d++) begin
            hs_cnt[d] = 0; hs_first[d] = 0; hs_last[d] = 0; sr_cnt[d] = 0;
        end
    endfunction

    task automatic cycle();
        sub_t e;
        logic exp_sr;
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk($sformatf("rst_mvalid%0d", d), mval[d], 1'b0);
                chk($sformatf("rst_sready%0d", d), srdy[d], 1'b1);
                exp_q[d].delete();
                stall_prev[d] = 1'b0;
                acc[d] = 1'b0;
                continue;
            end
            chk($sformatf("mvalid%0d", d), mval[d], exp_q[d].size() != 0);
            exp_sr = (exp_q[d].size() == 0) || (mrdy[d] && exp_q[d][0].fin);
            chk($sformatf("sready%0d", d), srdy[d], exp_sr);
            if (stall_prev[d]) begin
                chk($sformatf("stall_data%0d", d), mdat[d], pdat[d]);
                chk($sformatf("stall_keep%0d", d), mkeep[d], pkeep[d]);
                chk($sformatf("stall_user%0d", d), musr(d), pusr[d]);
                chk($sformatf("stall_last%0d", d), mlast[d], plast[d]);
            end
            if (mval[d] && mrdy[d] && exp_q[d].size() != 0) begin
                e = exp_q[d].pop_front();
                chk($sformatf("data%0d", d), mdat[d], e.data);
                chk($sformatf("keep%0d", d), mkeep[d], e.keep);
                chk($sformatf("user%0d", d), musr(d), e.user);
                chk($sformatf("last%0d", d), mlast[d], e.last);
                if (hs_cnt[d] == 0) hs_first[d] = cyc;
                hs_last[d] = cyc;
                hs_cnt[d]++;
                if (srdy[d]) sr_cnt[d]++;
            end
            stall_prev[d] = mval[d] && !mrdy[d];
            pdat[d]  = mdat[d];
            pkeep[d] = mkeep[d];
            pusr[d]  = musr(d);
            plast[d] = mlast[d];
            acc[d]   = svld[d] && srdy[d];
            if (acc[d]) expand(d, cur[d]);
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        while ((src_q[0].size() + src_q[1].size() != 0 || svld[0] || svld[1] ||
                exp_q[0].size() + exp_q[1].size() != 0) && n < 20000) begin
            cycle();
            n++;
        end
        chk("idle_timeout", n >= 20000, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        vprob = 100;
        rprob = 100;
        for (int d = 0; d < 2; d++) begin
            svld[d] = 1'b0; mrdy[d] = 1'b1; cur[d] = '0; acc[d] = 1'b0; stall_prev[d] = 1'b0;
        end
        reset_stats();
        repeat (3) cycle();

        // Split of a full beat, offered on the first edge after reset release
        rst_n = 1'b1;
        reset_stats();
        src_q[0].push_back(mk(64'hAABBCCDD, 8'hF, 2'b01, 1'b0));
        drive();
        run_idle();
        chk("r028_count", hs_cnt[0], 2);
        chk("r028_consec", hs_last[0] - hs_first[0], 1);

        reset_stats();
        src_q[0].push_back(mk(64'h12345678, 8'h3, 2'b00, 1'b1));
        run_idle();
        chk("r029_count", hs_cnt[0], 1);

        reset_stats();
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b = rand_beat(0);
            b.last = 1'b0;
            src_q[0].push_back(b);
        end
        run_idle();
        chk("r030_count", hs_cnt[0], 8);
        chk("r030_span", hs_last[0] - hs_first[0], 7);
        chk("r030_sready_hi", sr_cnt[0], 4);

        reset_stats();
        rdy_script = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        src_q[0].push_back(mk(64'hDEADBEEF, 8'hF, 2'b01, 1'b0));
        run_idle();
        chk("r031_count", hs_cnt[0], 2);
        chk("r031_span", hs_last[0] - hs_first[0], 1);

        reset_stats();
        src_q[1].push_back(mk({$urandom, $urandom}, 8'h00, 2'b10, 1'b1));
        src_q[1].push_back(mk({$urandom, $urandom}, 8'h30, 2'b11, 1'b1));
        run_idle();
        chk("r032_count", hs_cnt[1], 4);

        vprob = 60;
        rprob = 70;
        for (int i = 0; i < 150; i++) begin
            src_q[0].push_back(rand_beat(0));
            src_q[1].push_back(rand_beat(1));
        end
        run_idle();
        vprob = 100;
        rprob = 100;

        // Reset in the middle of a beat throws away its remaining sub-word
        reset_stats();
        src_q[0].push_back(mk(64'h11112222, 8'hF, 2'b00, 1'b0));
        n = 0;
        while (hs_cnt[0] == 0 && n < 100) begin
            cycle();
            n++;
        end
        chk("r033_first", hs_cnt[0], 1);
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        reset_stats();
        src_q[0].push_back(mk(64'hAAAA5555, 8'hF, 2'b01, 1'b0));
        drive();
        run_idle();
        chk("r033_after", hs_cnt[0], 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_downsizer.md
AXIS_DOWNSIZER -- requirements
Module: axis_downsizer

Interface
REQ-001 Parameter in_width, default 32, meaning input data width in bits; multiple of 8.
REQ-002 Parameter out_width, default 16, meaning output data width in bits; multiple of 8; in_width/out_width = RATIO, a power of 2, >=2.
REQ-003 Parameter user_width, default 1, meaning user signal width; >=1.
REQ-004 Parameter simulation_delay, default 1, meaning register-assignment delay for simulation only.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 s_axis_data/keep/user/last/valid  input  in_width/in_width/8/user_width/1/1  AXIS slave payload and valid.
REQ-008 s_axis_ready  output  1  slave ready.
REQ-009 m_axis_data/keep/user/last/valid  output  out_width/out_width/8/user_width/1/1  AXIS master payload and valid.
REQ-010 m_axis_ready  input  1  master ready.

Function
REQ-011 Block SHALL hold one input beat in a holding register; flag full = beat held.
REQ-012 s_axis_ready SHALL be 1 when not full, or when the final sub-word of the held beat is being accepted this cycle (m_axis_valid & m_axis_ready & final).
REQ-013 Input handshake (s_valid & s_ready) SHALL load the holding register, set full, and reset sub-word index idx to 0; m_axis_valid rises the following cycle (latency 1).
REQ-014 m_axis_valid SHALL equal full; m_axis_data/keep SHALL be slice idx of the held data/keep: bits [(idx+1)*out_width-1 : idx*out_width], LSB sub-word first.
REQ-015 m_axis_user SHALL equal the held user on every sub-word of the beat.
REQ-016 Final index SHALL be RATIO-1 for beats with last=0; for beats with last=1, the highest idx whose keep slice is non-zero, or 0 if held keep is all-zero.
REQ-017 m_axis_last SHALL be 1 only on the final sub-word of a beat held with last=1.
REQ-018 Output handshake on a non-final sub-word SHALL increment idx; on the final sub-word SHALL clear full unless a new input handshake occurs in the same cycle, which reloads (back-to-back, no bubble).
REQ-019 With m_axis_ready held 1 the block SHALL sustain one output sub-word per cycle.
REQ-020 Output payload SHALL remain stable while m_axis_valid=1 and m_axis_ready=0.
REQ-021 Intermediate sub-words with keep slice zero on non-final positions SHALL still be emitted unchanged.
REQ-022 idx width SHALL be clog2(RATIO); no wrap beyond final index SHALL occur.

Reset
REQ-023 During rst_n=0: full=0, idx=0, m_axis_valid=0, s_axis_ready=1; holding payload registers need no reset.
REQ-024 Reset asserted mid-beat SHALL discard the held beat; no partial sub-words emitted after release.
REQ-025 First input handshake SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-026 A shared package SHALL provide the clog2 function and the RATIO computation; no block-local typedefs.
REQ-027 Block SHALL be a single module with no sub-module; optional output timing isolation uses a separately instantiated axis_reg_slice at integration level.

Verification
REQ-028 32->16, m_ready=1, input data 0xAABBCCDD keep 0xF last=0 -> outputs 0xCCDD keep 0x3 last=0, then 0xAABB keep 0x3 last=0 on consecutive cycles.
REQ-029 32->16, last beat keep 0x3 data 0x1234_5678 last=1 -> single output 0x5678 keep 0x3 last=1; s_ready high again the same cycle.
REQ-030 32->16, 4 back-to-back beats, m_ready=1 -> 8 outputs in 8 consecutive cycles, no bubble, s_ready pattern 1,0,1,0...
REQ-031 m_ready toggled 1,0,0,1 on sub-word 0 -> m_data held stable while stalled, idx advances only on handshake, s_ready=0 throughout.
REQ-032 64->16, last beat keep 0x00 -> one output keep 0x0 last=1; keep 0x30 -> three outputs, last=1 on idx 2.
REQ-033 rst_n pulsed low after first sub-word of beat 0x11112222 -> m_valid=0 within reset, no 0x1111 emitted after release, next beat starts at idx 0.
